rbm_gibbs_scheduler: RTL and testbench
======================================

// Module: rbm_gibbs_scheduler
// PURPOSE
//  Sequences one hidden RBMLayer (visible->hidden) and one visible RBMLayer (hidden->visible)
//  through k contrastive-divergence Gibbs steps: H, (V, H) x k. Each phase is started by a
//  layer reset pulse, held in data_valid until the layer's finish, then latched.
//  Sits between the sample loader and the weight-update logic.
// PARAMETERS
//  visible_dim     15    visible units (hidden layer input width, visible layer output width)
//  hidden_dim      5     hidden units
//  step_bits       4     width of cfg_steps / step counter
//  timeout_cycles  1023  max cycles per RUN phase (only with RBM_SCHED_TIMEOUT_EN)
// PORTS
//  clock           in   1           system clock
//  reset_n         in   1           asynchronous, active-low reset
//  start           in   1           job request; sampled only in IDLE
//  cfg_steps       in   step_bits   Gibbs steps k, sampled with start
//  visible_in      in   visible_dim initial visible vector v0, sampled with start
//  busy            out  1           high from accepted start until DONE inclusive
//  done            out  1           1-cycle pulse at end of job
//  error           out  1           phase timeout flag (sticky until next accepted start)
//  visible_out     out  visible_dim latest visible vector (v0 until first V phase ends)
//  hidden_out      out  hidden_dim  latest hidden sample
//  lay_rand_reset  out  1           RandomGenerator reset to both layers
//  hid_reset       out  1           active-high reset to hidden layer
//  hid_valid       out  1           data_valid to hidden layer
//  hid_input       out  visible_dim = visible_out
//  hid_output      in   hidden_dim  hidden layer OutputData
//  hid_finish      in   1           hidden layer finish
//  vis_reset, vis_valid, vis_input (hidden_dim = hidden_out), vis_output (visible_dim), vis_finish:
//                                   same roles for the visible layer
// BEHAVIOUR
//  - reset_n low (any time, incl. mid-job): state=IDLE; busy=done=error=0; visible_out=0;
//    hidden_out=0; step_cnt=0; hid_reset=vis_reset=lay_rand_reset=1; valids=0.
//  - States: IDLE, H_CLR, H_RUN, V_CLR, V_RUN, DONE. Moore outputs decoded from state register.
//  - IDLE: both layer resets=1, lay_rand_reset=1. start=1 -> latch visible_in->visible_out,
//    cfg_steps->k_reg, step_cnt=0, error=0; go H_CLR.
//  - H_CLR (1 cycle): hid_reset=1, hid_valid=0; lay_rand_reset=1 only when step_cnt==0
//    (first phase of the job). -> H_RUN.
//  - H_RUN: hid_reset=0, hid_valid=1. On hid_finish: hidden_out<=hid_output;
//    step_cnt==k_reg -> DONE, else -> V_CLR.
//  - V_CLR (1 cycle): vis_reset=1, vis_valid=0 -> V_RUN.
//  - V_RUN: vis_valid=1. On vis_finish: visible_out<=vis_output, step_cnt++ -> H_CLR.
//  - DONE (1 cycle): done=1, busy=1; start ignored here; -> IDLE.
//  - The idle layer of a pair is held in reset (its _reset=1) during the other's phase.
//  - start while busy: ignored, no effect on latched config.
//  - finish is only acted on in the matching RUN state; finish of the other layer ignored.
//  - k=0: single H phase, V layer never released from reset. Phases per job = 2k+1.
//  - Job latency = sum of phase lengths + (2k+1) CLR cycles + 1 (DONE) + 1 (accept).
//  - step_cnt width step_bits; k_reg <= 2^step_bits-1, no wrap possible.
// CONFIGURATION
//  RBM_SCHED_TIMEOUT_EN defined: phase counter clog2(timeout_cycles+1) bits, cleared in each
//    CLR state, increments each RUN cycle; reaching timeout_cycles without finish ->
//    error=1, outputs not updated for that phase, go DONE (done pulses normally).
//  Not defined: no counter, error tied 0, RUN waits for finish indefinitely.
// TESTING (behavioural layer models: finish N cycles after first valid cycle, fixed output)
//  1 reset_n=0 mid-sim -> busy=done=error=0, hid_reset=vis_reset=lay_rand_reset=1, outs=0.
//  2 k=0, visible_in=15'h1234, hid model N=10 out 5'b10101 -> hidden_out=10101,
//    visible_out=1234, one done pulse, vis_valid never 1, busy high 13 cycles.
//  3 k=2 -> hid_reset pulses 3, vis_reset pulses 2, lay_rand_reset 1 pulse (first H_CLR);
//    visible_out = last vis model output, hidden_out = last hid model output.
//  4 start held high through job -> exactly one job; new job starts the cycle after DONE.
//  5 reset_n low during V_RUN of k=3 job -> IDLE next edge, no done; new k=1 start runs 3 phases.
//  6 TIMEOUT_EN, timeout_cycles=20, hid_finish stuck 0 -> error=1, done after 20 RUN cycles,
//    hidden_out unchanged; without macro busy stays 1 at cycle 200.

Source files
------------

// File: rtl/rbm_gibbs_scheduler.sv
// rbm_gibbs_scheduler
//   Drives a hidden RBM layer (visible->hidden) and a visible RBM layer
//   (hidden->visible) through k contrastive-divergence Gibbs steps:
//   H, (V, H) x k. Each phase starts with a one-cycle layer reset, then
//   holds data_valid until the layer reports finish, then latches the
//   layer output.
//   Optional feature macro: RBM_SCHED_TIMEOUT_EN adds a per-phase watchdog
//   that aborts a stuck RUN phase and raises the sticky error flag.
//   All outputs are registered and take the value decoded from the next
//   state, so they behave as Moore outputs of the state register.
module rbm_gibbs_scheduler #(
    parameter int visible_dim    = 15,
    parameter int hidden_dim     = 5,
    parameter int step_bits      = 4,
    parameter int timeout_cycles = 1023
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [step_bits-1:0]   cfg_steps,
    input  logic [visible_dim-1:0] visible_in,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [visible_dim-1:0] visible_out,
    output logic [hidden_dim-1:0]  hidden_out,
    output logic                   lay_rand_reset,
    output logic                   hid_reset,
    output logic                   hid_valid,
    output logic [visible_dim-1:0] hid_input,
    input  logic [hidden_dim-1:0]  hid_output,
    input  logic                   hid_finish,
    output logic                   vis_reset,
    output logic                   vis_valid,
    output logic [hidden_dim-1:0]  vis_input,
    input  logic [visible_dim-1:0] vis_output,
    input  logic                   vis_finish
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_H_CLR = 3'd1,
        S_H_RUN = 3'd2,
        S_V_CLR = 3'd3,
        S_V_RUN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [step_bits-1:0]   k_q, k_d;
    logic [step_bits-1:0]   step_cnt_q, step_cnt_d;
    logic [visible_dim-1:0] visible_q, visible_d;
    logic [hidden_dim-1:0]  hidden_q, hidden_d;
    logic                   error_q, error_d;
    logic                   timeout_s;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic lay_rand_q, lay_rand_d;
    logic hid_reset_q, hid_reset_d;
    logic hid_valid_q, hid_valid_d;
    logic vis_reset_q, vis_reset_d;
    logic vis_valid_q, vis_valid_d;

`ifdef RBM_SCHED_TIMEOUT_EN
    localparam int TIMER_W = $clog2(timeout_cycles + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(timeout_cycles - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;

    // Phase watchdog: cleared in each CLR state, counts every RUN cycle.
    always_comb begin
        timer_d = timer_q;
        if ((state_q == S_H_CLR) || (state_q == S_V_CLR)) begin
            timer_d = '0;
        end else if ((state_q == S_H_RUN) || (state_q == S_V_RUN)) begin
            timer_d = timer_q + TIMER_W'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    // Phase timer register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // The last allowed RUN cycle has elapsed without a finish.
    assign timeout_s = (timer_q == TIMER_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and datapath update: walk H, (V, H) x k and latch layer results.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        step_cnt_d = step_cnt_q;
        visible_d  = visible_q;
        hidden_d   = hidden_q;
        error_d    = error_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    visible_d  = visible_in;
                    k_d        = cfg_steps;
                    step_cnt_d = '0;
                    error_d    = 1'b0;
                    state_d    = S_H_CLR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_H_CLR: begin
                state_d = S_H_RUN;
            end
            S_H_RUN: begin
                if (hid_finish) begin
                    hidden_d = hid_output;
                    if (step_cnt_q == k_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_V_CLR;
                    end
                end else if (timeout_s) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_H_RUN;
                end
            end
            S_V_CLR: begin
                state_d = S_V_RUN;
            end
            S_V_RUN: begin
                if (vis_finish) begin
                    visible_d  = vis_output;
                    step_cnt_d = step_cnt_q + step_bits'(1);
                    state_d    = S_H_CLR;
                end else if (timeout_s) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_V_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state; the idle layer of the pair stays in reset.
    always_comb begin
        busy_d      = 1'b1;
        done_d      = 1'b0;
        lay_rand_d  = 1'b0;
        hid_reset_d = 1'b1;
        hid_valid_d = 1'b0;
        vis_reset_d = 1'b1;
        vis_valid_d = 1'b0;
        case (state_d)
            S_IDLE: begin
                busy_d     = 1'b0;
                lay_rand_d = 1'b1;
            end
            S_H_CLR: begin
                // Random generators are reseeded only before the first phase of a job.
                lay_rand_d = (step_cnt_d == '0);
            end
            S_H_RUN: begin
                hid_reset_d = 1'b0;
                hid_valid_d = 1'b1;
            end
            S_V_CLR: begin
                vis_reset_d = 1'b1;
            end
            S_V_RUN: begin
                vis_reset_d = 1'b0;
                vis_valid_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d     = 1'b0;
                lay_rand_d = 1'b1;
            end
        endcase
    end

    // State, configuration, result and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            step_cnt_q  <= '0;
            visible_q   <= '0;
            hidden_q    <= '0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            lay_rand_q  <= 1'b1;
            hid_reset_q <= 1'b1;
            hid_valid_q <= 1'b0;
            vis_reset_q <= 1'b1;
            vis_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            step_cnt_q  <= step_cnt_d;
            visible_q   <= visible_d;
            hidden_q    <= hidden_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            lay_rand_q  <= lay_rand_d;
            hid_reset_q <= hid_reset_d;
            hid_valid_q <= hid_valid_d;
            vis_reset_q <= vis_reset_d;
            vis_valid_q <= vis_valid_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign visible_out    = visible_q;
    assign hidden_out     = hidden_q;
    assign lay_rand_reset = lay_rand_q;
    assign hid_reset      = hid_reset_q;
    assign hid_valid      = hid_valid_q;
    assign hid_input      = visible_q;
    assign vis_reset      = vis_reset_q;
    assign vis_valid      = vis_valid_q;
    assign vis_input      = hidden_q;

endmodule

// File: tb/tb_rbm_gibbs_scheduler.sv
// Testbench for rbm_gibbs_scheduler: table-driven jobs, randomized jobs
// checked against a job-level model, and hand-written reset / held-start /
// stuck-layer sequences. Define RBM_SCHED_TIMEOUT_EN to check the watchdog.
module tb_rbm_gibbs_scheduler;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  cfg_steps = 4'd0;
    logic [14:0] visible_in = 15'd0;
    logic        busy, done, error;
    logic [14:0] visible_out, hid_input, vis_output;
    logic [4:0]  hidden_out, vis_input, hid_output;
    logic        lay_rand_reset, hid_reset, hid_valid, hid_finish;
    logic        vis_reset, vis_valid, vis_finish;

    // Behavioural layer models: finish N cycles after the first valid cycle.
    int          h_n = 0, v_n = 0, h_cnt = 0, v_cnt = 0;
    bit          h_stuck = 1'b0;
    logic [4:0]  h_val = 5'd0;
    logic [14:0] v_val = 15'd0;

    int n_pass = 0;
    int n_total = 0;

    rbm_gibbs_scheduler #(
        .visible_dim(15), .hidden_dim(5), .step_bits(4), .timeout_cycles(20)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .cfg_steps(cfg_steps),
        .visible_in(visible_in), .busy(busy), .done(done), .error(error),
        .visible_out(visible_out), .hidden_out(hidden_out),
        .lay_rand_reset(lay_rand_reset), .hid_reset(hid_reset), .hid_valid(hid_valid),
        .hid_input(hid_input), .hid_output(hid_output), .hid_finish(hid_finish),
        .vis_reset(vis_reset), .vis_valid(vis_valid), .vis_input(vis_input),
        .vis_output(vis_output), .vis_finish(vis_finish)
    );

    always #5 clock = ~clock;

    assign hid_output = h_val;
    assign vis_output = v_val;
    assign hid_finish = hid_valid && !hid_reset && !h_stuck && (h_cnt == h_n);
    assign vis_finish = vis_valid && !vis_reset && (v_cnt == v_n);

    // Hidden layer model: count valid cycles since its reset.
    always @(posedge clock) begin
        if (hid_reset) h_cnt <= 0;
        else if (hid_valid) h_cnt <= h_cnt + 1;
    end

    // Visible layer model: count valid cycles since its reset.
    always @(posedge clock) begin
        if (vis_reset) v_cnt <= 0;
        else if (vis_valid) v_cnt <= v_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Job-level model: CLR cycles, H and V run lengths, DONE.
    function automatic int model_busy(input int k, input int nh, input int nv);
        return (2 * k + 1) + (k + 1) * (nh + 1) + k * (nv + 1) + 1;
    endfunction

    task automatic run_job(input int k, input logic [14:0] v0, input logic [4:0] hv,
                           input logic [14:0] vv, input int nh, input int nv, input bit extra,
                           output int busy_c, output int done_c, output int hf,
                           output int vf, output int lf, output bit vval_seen, output bit err_seen);
        bit ph, pv, pl;
        h_n = nh; h_val = hv; v_n = nv; v_val = vv;
        busy_c = 0; done_c = 0; hf = 0; vf = 0; lf = 0; vval_seen = 1'b0; err_seen = 1'b0;
        ph = 1'b1; pv = 1'b1; pl = 1'b1;
        @(negedge clock);
        start = 1'b1; cfg_steps = 4'(k); visible_in = v0;
        @(negedge clock);
        start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (busy) busy_c++;
            if (done) done_c++;
            if (error) err_seen = 1'b1;
            if (vis_valid) vval_seen = 1'b1;
            if (ph && !hid_reset) hf++;
            if (pv && !vis_reset) vf++;
            if (pl && !lay_rand_reset) lf++;
            ph = hid_reset; pv = vis_reset; pl = lay_rand_reset;
            if (cyc == 3) start = 1'b0;
            if (done_c > 0 && !busy) break;
            if (cyc == 2 && extra) begin
                start = 1'b1;
                cfg_steps = 4'($urandom);
                visible_in = 15'($urandom);
            end
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    task automatic check_job(input string tag, input int k, input logic [14:0] v0,
                             input logic [4:0] hv, input logic [14:0] vv, input int nh,
                             input int nv, input bit extra, input logic [4:0] exp_h,
                             input logic [14:0] exp_v, input int exp_busy);
        int bc, dc, hf, vf, lf;
        bit vs, es;
        run_job(k, v0, hv, vv, nh, nv, extra, bc, dc, hf, vf, lf, vs, es);
        chk({tag, "_hidden"}, 32'(hidden_out), 32'(exp_h));
        chk({tag, "_visible"}, 32'(visible_out), 32'(exp_v));
        chk({tag, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
        chk({tag, "_done_pulses"}, 32'(dc), 32'd1);
        chk({tag, "_hid_reset_pulses"}, 32'(hf), 32'(k + 1));
        chk({tag, "_vis_reset_pulses"}, 32'(vf), 32'(k));
        chk({tag, "_lay_rand_pulses"}, 32'(lf), 32'd1);
        chk({tag, "_vis_valid_seen"}, 32'(vs), 32'(k > 0));
        chk({tag, "_error"}, 32'(es), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_resets"}, {29'd0, hid_reset, vis_reset, lay_rand_reset}, 32'd7);
        chk({tag, "_valids"}, {30'd0, hid_valid, vis_valid}, 32'd0);
        chk({tag, "_visible_out"}, 32'(visible_out), 32'd0);
        chk({tag, "_hidden_out"}, 32'(hidden_out), 32'd0);
    endtask

    typedef struct {
        int          k;
        logic [14:0] v0;
        logic [4:0]  hv;
        logic [14:0] vv;
        int          nh;
        int          nv;
        logic [4:0]  exp_h;
        logic [14:0] exp_v;
        int          exp_busy;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int k, nh, nv, dc, bc;
        bit got;
        logic [14:0] v0, vv;
        logic [4:0] hv, prev_h;

        tbl[0] = '{0, 15'h1234, 5'b10101, 15'h7fff, 10, 3, 5'b10101, 15'h1234, 13};
        tbl[1] = '{2, 15'h0001, 5'h0a, 15'h5555, 2, 4, 5'h0a, 15'h5555, 25};
        tbl[2] = '{1, 15'h7fff, 5'h1f, 15'h0000, 0, 0, 5'h1f, 15'h0000, 7};
        tbl[3] = '{15, 15'h2a2a, 5'h03, 15'h1357, 0, 0, 5'h03, 15'h1357, 63};

        // Power-on reset.
        #2 reset_n = 1'b0;
        #1 check_reset_state("por");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Table-driven jobs.
        for (int i = 0; i < 4; i++) begin
            check_job($sformatf("tbl%0d", i), tbl[i].k, tbl[i].v0, tbl[i].hv, tbl[i].vv,
                      tbl[i].nh, tbl[i].nv, 1'b0, tbl[i].exp_h, tbl[i].exp_v, tbl[i].exp_busy);
        end

        // Randomized jobs against the job-level model, some with a stray start mid-job.
        for (int i = 0; i < 8; i++) begin
            k  = int'($urandom_range(0, 5));
            nh = int'($urandom_range(0, 6));
            nv = int'($urandom_range(0, 6));
            v0 = 15'($urandom);
            vv = 15'($urandom);
            hv = 5'($urandom);
            check_job($sformatf("rnd%0d", i), k, v0, hv, vv, nh, nv, 1'($urandom),
                      hv, (k == 0) ? v0 : vv, model_busy(k, nh, nv));
        end

        // Start held high: one job, then a new one accepted in the IDLE cycle after DONE.
        h_n = 1; v_n = 1; h_val = 5'h06; v_val = 15'h0abc;
        @(negedge clock);
        start = 1'b1; cfg_steps = 4'd1; visible_in = 15'h0111;
        bc = 0; got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clock);
            if (busy) bc++;
            if (done) got = 1'b1;
        end
        chk("hold_first_done", 32'(got), 32'd1);
        chk("hold_busy_cycles", 32'(bc), 32'(model_busy(1, 1, 1)));
        @(negedge clock);
        chk("hold_gap_idle", 32'(busy), 32'd0);
        chk("hold_no_extra_done", 32'(done), 32'd0);
        @(negedge clock);
        chk("hold_restart", 32'(busy), 32'd1);
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clock);
            if (done) got = 1'b1;
        end
        chk("hold_second_done", 32'(got), 32'd1);
        chk("hold_visible", 32'(visible_out), 32'h0abc);
        @(negedge clock);

        // Reset during V_RUN of a k=3 job; then a k=1 job runs 3 phases.
        h_n = 3; v_n = 4;
        @(negedge clock);
        start = 1'b1; cfg_steps = 4'd3; visible_in = 15'h0f0f;
        @(negedge clock);
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clock);
            if (vis_valid) got = 1'b1;
        end
        chk("midrst_reach_vrun", 32'(got), 32'd1);
        reset_n = 1'b0;
        #1 check_reset_state("midrst");
        dc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (done) dc++;
        end
        chk("midrst_no_done", 32'(dc), 32'd0);
        reset_n = 1'b1;
        check_job("post_rst_k1", 1, 15'h0042, 5'h11, 15'h3210, 2, 2, 1'b0,
                  5'h11, 15'h3210, model_busy(1, 2, 2));

        // Hidden layer never finishes.
        prev_h = hidden_out;
        h_stuck = 1'b1; h_val = 5'h0e;
        @(negedge clock);
        start = 1'b1; cfg_steps = 4'd0; visible_in = 15'h0001;
        @(negedge clock);
        start = 1'b0;
`ifdef RBM_SCHED_TIMEOUT_EN
        bc = 0; got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            if (busy) bc++;
            if (done) got = 1'b1;
            if (!got) @(negedge clock);
        end
        chk("timeout_done", 32'(got), 32'd1);
        chk("timeout_busy_cycles", 32'(bc), 32'd22);
        chk("timeout_error", 32'(error), 32'd1);
        chk("timeout_hidden_kept", 32'(hidden_out), 32'(prev_h));
        @(negedge clock);
        chk("timeout_error_sticky", 32'(error), 32'd1);
`else
        dc = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (done) dc++;
        end
        chk("stuck_busy_at_200", 32'(busy), 32'd1);
        chk("stuck_no_done", 32'(dc), 32'd0);
        chk("stuck_no_error", 32'(error), 32'd0);
        chk("stuck_hidden_kept", 32'(hidden_out), 32'(prev_h));
`endif
        h_stuck = 1'b0;
        reset_n = 1'b0;
        #1 check_reset_state("final_rst");
        @(negedge clock);
        reset_n = 1'b1;
        check_job("after_stuck", 0, 15'h0777, 5'h19, 15'h0000, 1, 1, 1'b0,
                  5'h19, 15'h0777, model_busy(0, 1, 1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
